// File: rtl/huc6280_bus_responder_if.sv
// Bus bundle between the HuC6280 core (plus external ROM) and the bus responder.
// The master side is the CPU/ROM environment; the slave side is the responder.
interface huc6280_bus_responder_if;
  logic [20:0] AB_21;
  logic [7:0]  DO;
  logic        RE;
  logic        WE;
  logic [7:0]  DI;
  logic        RDY_n;
  logic        rom_req;
  logic [19:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_ack;
  logic        rom_err;
  logic        sim_done;
  logic [7:0]  sim_code;

  modport master (
    output AB_21, DO, RE, WE, rom_data, rom_ack,
    input  DI, RDY_n, rom_req, rom_addr, rom_err, sim_done, sim_code
  );

  modport slave (
    input  AB_21, DO, RE, WE, rom_data, rom_ack,
    output DI, RDY_n, rom_req, rom_addr, rom_err, sim_done, sim_code
  );
endinterface

// File: rtl/huc6280_bus_responder.sv
// Responder for the HuC6280 21-bit physical bus: work RAM, handshaked ROM port
// with timeout, and a write-only simulation mailbox. Stalls the CPU via RDY_n.
module huc6280_bus_responder #(
  parameter logic [7:0]  RAM_SEG       = 8'hF8,
  parameter logic [7:0]  ROM_SEG_LIMIT = 8'h80,
  parameter logic [20:0] MBOX_ADDR     = 21'h1FFFF0,
  parameter int          ROM_TIMEOUT   = 255
) (
  input logic                      clk,
  input logic                      reset,
  huc6280_bus_responder_if.slave   bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [7:0] TMO    = ROM_TIMEOUT[7:0];

  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic [7:0]  r_di;
  logic        r_rom_req;
  logic [19:0] r_rom_addr;
  logic        r_rom_err;
  logic        r_sim_done;
  logic [7:0]  r_sim_code;
  logic [7:0]  r_ram [0:8191];

  logic [7:0]  w_seg;
  logic [12:0] w_off;
  logic        w_is_mbox;
  logic        w_is_ram;
  logic        w_is_rom;
  logic        w_idle;
  logic        w_ram_we;

  assign w_seg     = bus.AB_21[20:13];
  assign w_off     = bus.AB_21[12:0];
  assign w_is_mbox = (bus.AB_21 == MBOX_ADDR);
  assign w_is_ram  = !w_is_mbox && (w_seg == RAM_SEG);
  assign w_is_rom  = !w_is_mbox && !w_is_ram && (w_seg < ROM_SEG_LIMIT);
  assign w_idle    = (r_state == S_IDLE);
  // Accesses are only taken in IDLE; WAIT and DONE belong to the pending ROM read.
  assign w_ram_we  = w_idle && bus.WE && w_is_ram;

  assign bus.RDY_n    = (r_state == S_WAIT) ||
                        (w_idle && bus.RE && !bus.WE && w_is_rom);
  assign bus.DI       = r_di;
  assign bus.rom_req  = r_rom_req;
  assign bus.rom_addr = r_rom_addr;
  assign bus.rom_err  = r_rom_err;
  assign bus.sim_done = r_sim_done;
  assign bus.sim_code = r_sim_code;

  always_ff @(posedge clk) begin
    if (w_ram_we) r_ram[w_off] <= bus.DO;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_di       <= 8'hFF;
      r_rom_req  <= 1'b0;
      r_rom_addr <= 20'd0;
      r_rom_err  <= 1'b0;
      r_sim_done <= 1'b0;
      r_sim_code <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.WE) begin
            if (w_is_mbox) begin
              r_sim_code <= bus.DO;
              r_sim_done <= 1'b1;
            end
          end else if (bus.RE) begin
            if (w_is_rom) begin
              r_rom_addr <= {w_seg[6:0], w_off};
              r_rom_req  <= 1'b1;
              r_cnt      <= 8'd0;
              r_state    <= S_WAIT;
            end else if (w_is_ram) begin
              r_di <= r_ram[w_off];
            end else begin
              r_di <= 8'hFF;
            end
          end
        end
        S_WAIT: begin
          // An ack on the timeout cycle still delivers data.
          if (bus.rom_ack) begin
            r_di      <= bus.rom_data;
            r_rom_req <= 1'b0;
            r_state   <= S_DONE;
          end else if (r_cnt == TMO) begin
            r_di      <= 8'hFF;
            r_rom_err <= 1'b1;
            r_rom_req <= 1'b0;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_huc6280_bus_responder.sv
// Scoreboard bench for huc6280_bus_responder: stimulus pushes expected read data,
// a negedge monitor pops and compares whenever a read completes.
module tb_huc6280_bus_responder;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ack_resp = 1'b0;
  logic ack_late = 1'b0;
  int   rom_lat = 0;
  int   vectors = 0;
  int   miscompares = 0;

  logic [7:0] exp_q [$];
  logic [7:0] ram_m [0:8191];
  logic       err_m = 1'b0;
  logic       done_m = 1'b0;
  logic [7:0] code_m = 8'd0;

  huc6280_bus_responder_if bus ();
  assign bus.rom_ack = ack_resp | ack_late;

  huc6280_bus_responder #(.ROM_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rom_byte(input logic [19:0] a);
    return a[7:0] ^ a[19:12] ^ 8'h81;
  endfunction

  // 0 = mailbox, 1 = RAM, 2 = ROM, 3 = unmapped
  function automatic int target(input logic [20:0] a);
    if (a == 21'h1FFFF0) return 0;
    if (a[20:13] == 8'hF8) return 1;
    if (a[20:13] < 8'h80) return 2;
    return 3;
  endfunction

  // ROM device: acks in WAIT cycle rom_lat (0 = first cycle rom_req is seen).
  int wcnt = 0;
  always @(negedge clk) begin
    ack_resp = 1'b0;
    if (bus.rom_req === 1'b1 && !reset) begin
      if (wcnt == rom_lat) begin
        ack_resp = 1'b1;
        bus.rom_data = rom_byte(bus.rom_addr);
      end
      wcnt++;
    end else begin
      wcnt = 0;
    end
  end

  // Monitor: read data is due one cycle after an accepted non-stalled read,
  // or in the first non-stalled cycle following a stall (ROM DONE).
  logic pend = 1'b0;
  logic prev_stall = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      pend = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (pend || (prev_stall && !bus.RDY_n)) begin
        if (exp_q.size() == 0) chk("unexpected_read", 32'(bus.DI), 32'hDEAD);
        else chk("read_data", 32'(bus.DI), 32'(exp_q.pop_front()));
      end
      pend = bus.RE && !bus.WE && !bus.RDY_n && !prev_stall;
      prev_stall = bus.RDY_n;
    end
  end

  task automatic access(input logic [20:0] a, input logic [7:0] d,
                        input logic re, input logic we, input int lat);
    int t;
    int hi;
    rom_lat = lat;
    @(posedge clk); #1;
    bus.AB_21 = a; bus.DO = d; bus.RE = re; bus.WE = we;
    t = target(a);
    if (we) begin
      if (t == 0) begin code_m = d; done_m = 1'b1; end
      else if (t == 1) ram_m[a[12:0]] = d;
    end else if (re && t == 2) begin
      exp_q.push_back((lat <= TMO) ? rom_byte(a[19:0]) : 8'hFF);
      if (lat > TMO) err_m = 1'b1;
    end else if (re) begin
      exp_q.push_back((t == 1) ? ram_m[a[12:0]] : 8'hFF);
    end
    if (re && !we && t == 2) begin
      hi = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (!bus.RDY_n) break;
        hi++;
        if (hi == 2) begin
          chk("rom_addr", 32'(bus.rom_addr), 32'({a[19:13], a[12:0]}));
          chk("rom_req_wait", 32'(bus.rom_req), 32'd1);
        end
      end
      chk("rom_stall_cycles", 32'(hi), 32'((lat <= TMO) ? lat + 2 : TMO + 2));
    end else begin
      @(negedge clk);
      chk("no_stall", 32'(bus.RDY_n), 32'd0);
      if (we && t == 2) chk("rom_wr_no_req", 32'(bus.rom_req), 32'd0);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    bus.RE = 1'b0; bus.WE = 1'b0;
  endtask

  initial begin
    logic [20:0] a;
    logic [7:0]  d;
    int          k;
    bus.AB_21 = '0; bus.DO = '0; bus.RE = 1'b0; bus.WE = 1'b0; bus.rom_data = '0;

    repeat (2) @(negedge clk);
    chk("rst_DI", 32'(bus.DI), 32'hFF);
    chk("rst_RDY_n", 32'(bus.RDY_n), 32'd0);
    chk("rst_rom_req", 32'(bus.rom_req), 32'd0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    chk("rst_rom_err", 32'(bus.rom_err), 32'd0);
    chk("rst_sim_done", 32'(bus.sim_done), 32'd0);
    chk("rst_sim_code", 32'(bus.sim_code), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // RAM round trip, ROM read with 3-cycle ack, ack/timeout collision
    access(21'h1F0020, 8'h5A, 1'b0, 1'b1, 0);
    access(21'h1F0020, 8'h00, 1'b1, 1'b0, 0);
    access(21'h00E226, 8'h00, 1'b1, 1'b0, 2);
    access(21'h012345, 8'h00, 1'b1, 1'b0, TMO);
    idle_cycle();
    @(negedge clk);
    chk("collision_no_err", 32'(bus.rom_err), 32'd0);

    // mailbox, unmapped, ROM write, mailbox-neighbour
    access(21'h1FFFF0, 8'h42, 1'b0, 1'b1, 0);
    @(negedge clk);
    chk("sim_done", 32'(bus.sim_done), 32'd1);
    chk("sim_code", 32'(bus.sim_code), 32'h42);
    access(21'h100000, 8'h00, 1'b1, 1'b0, 0);
    access(21'h000010, 8'h33, 1'b0, 1'b1, 0);
    access(21'h1FFFF0, 8'h00, 1'b1, 1'b0, 0);
    access(21'h1FFFEF, 8'h00, 1'b1, 1'b0, 0);

    // timeout, then a normal read still completes
    access(21'h034567, 8'h00, 1'b1, 1'b0, 9);
    access(21'h07FFFF, 8'h00, 1'b1, 1'b0, 1);
    idle_cycle();
    @(negedge clk);
    chk("timeout_err", 32'(bus.rom_err), 32'd1);

    // reset two cycles into WAIT, late ack afterwards
    rom_lat = 99;
    @(posedge clk); #1;
    bus.AB_21 = 21'h000100; bus.RE = 1'b1; bus.WE = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1; bus.RE = 1'b0;
    @(negedge clk);
    chk("rstw_RDY_n", 32'(bus.RDY_n), 32'd0);
    chk("rstw_rom_req", 32'(bus.rom_req), 32'd0);
    #2 reset = 1'b0;
    err_m = 1'b0; done_m = 1'b0; code_m = 8'd0;
    ack_late = 1'b1; bus.rom_data = 8'h3C;
    @(negedge clk);
    #2 ack_late = 1'b0;
    @(negedge clk);
    chk("late_ack_DI", 32'(bus.DI), 32'hFF);
    chk("late_ack_RDY_n", 32'(bus.RDY_n), 32'd0);
    chk("late_ack_rom_req", 32'(bus.rom_req), 32'd0);
    chk("rstw_rom_err", 32'(bus.rom_err), 32'd0);
    access(21'h1F0100, 8'h77, 1'b1, 1'b1, 0);
    @(negedge clk);
    chk("re_we_DI_held", 32'(bus.DI), 32'hFF);
    access(21'h1F0100, 8'h00, 1'b1, 1'b0, 0);

    // randomized traffic
    for (int i = 0; i < 32; i++) access({8'hF8, 13'(i)}, 8'($urandom), 1'b0, 1'b1, 0);
    for (int i = 0; i < 250; i++) begin
      k = $urandom_range(0, 8);
      d = 8'($urandom);
      case (k)
        0: access({8'hF8, 13'($urandom_range(0, 31))}, d, 1'b0, 1'b1, 0);
        1: access({8'hF8, 13'($urandom_range(0, 31))}, d, 1'b1, 1'b0, 0);
        2: access({8'($urandom_range(0, 127)), 13'($urandom)}, d, 1'b1, 1'b0,
                  $urandom_range(0, 6));
        3: access({8'($urandom_range(0, 127)), 13'($urandom)}, d, 1'b0, 1'b1, 0);
        4: access({8'($urandom_range(128, 247)), 13'($urandom)}, d,
                  1'($urandom), 1'($urandom), 0);
        5: access(21'h1FFFF0, d, 1'b0, 1'b1, 0);
        6: access(21'h1FFFF0, d, 1'b1, 1'b0, 0);
        7: access({8'hF8, 13'($urandom_range(0, 31))}, d, 1'b1, 1'b1, 0);
        default: begin
          a = {8'hFF, 13'($urandom_range(0, 13'h1FEF))};
          access(a, d, 1'b1, 1'b0, 0);
        end
      endcase
    end

    idle_cycle();
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("final_rom_err", 32'(bus.rom_err), 32'(err_m));
    chk("final_sim_done", 32'(bus.sim_done), 32'(done_m));
    chk("final_sim_code", 32'(bus.sim_code), 32'(code_m));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
